// File: rtl/lector_memoria_ventana.sv
// Sequential image-memory reader: issues reads from a latched start address and
// streams the returned words into a rotating set of internal line buffers.
module lector_memoria_ventana #(
   parameter int BITS_BUS_DATOS_INSTR = 24,
   parameter int BITS_DIRECCION_MEM   = 10,
   parameter int BITS_BUFFERS         = 3,
   parameter int BITS_DATOS_MEM       = 32,
   parameter int LATENCIA_MEM         = 1,
   parameter int PALABRAS_POR_BUFFER  = 128,
   parameter int BITS_PALABRAS        = 7
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            inicio,
   input  logic [BITS_DIRECCION_MEM-1:0]   direccion_mem_inicio_imagen,
   input  logic [BITS_BUS_DATOS_INSTR-1:0] cantidad_lecturas_mem,
   input  logic [BITS_BUFFERS-1:0]         cantidad_buffers_internos,
   input  logic                            buffer_listo,
   input  logic [BITS_DATOS_MEM-1:0]       dato_mem,
   output logic [BITS_DIRECCION_MEM-1:0]   direccion_mem,
   output logic                            lectura_mem,
   output logic [BITS_DATOS_MEM-1:0]       dato_buffer,
   output logic                            escritura_buffer,
   output logic [BITS_BUFFERS-1:0]         seleccion_buffer,
   output logic                            ocupado,
   output logic                            terminado
);

   localparam logic [BITS_PALABRAS-1:0] ULTIMA_PALABRA = BITS_PALABRAS'(PALABRAS_POR_BUFFER - 1);

   typedef enum logic [1:0] {REPOSO, LEYENDO, DRENANDO, FIN} estado_t;

   estado_t                         r_estado;
   estado_t                         w_estado_sig;
   logic [BITS_DIRECCION_MEM-1:0]   r_direccion;
   logic [BITS_BUS_DATOS_INSTR-1:0] r_restantes;
   logic [BITS_BUFFERS-1:0]         r_ultimo_buffer;
   logic [BITS_BUFFERS-1:0]         r_buffer;
   logic [BITS_BUFFERS-1:0]         r_seleccion;
   logic [BITS_PALABRAS-1:0]        r_palabra;
   logic [LATENCIA_MEM-1:0]         r_valido;
   logic [BITS_DATOS_MEM-1:0]       r_dato;
   logic                            r_escritura;
   logic                            w_lectura;
   logic                            w_arranque;
   logic                            w_ocupado;
   logic                            w_terminado;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado <= REPOSO;
      end else begin
         r_estado <= w_estado_sig;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_estado_sig = r_estado;
      w_lectura    = 1'b0;
      w_arranque   = 1'b0;
      w_ocupado    = 1'b1;
      w_terminado  = 1'b0;
      case (r_estado)
         REPOSO: begin
            w_ocupado = 1'b0;
            if (inicio) begin
               w_arranque   = 1'b1;
               w_estado_sig = (cantidad_lecturas_mem == '0) ? FIN : LEYENDO;
            end
         end
         LEYENDO: begin
            if (buffer_listo) begin
               w_lectura = 1'b1;
               if (r_restantes == BITS_BUS_DATOS_INSTR'(1)) begin
                  w_estado_sig = DRENANDO;
               end
            end
         end
         DRENANDO: begin
            // The last read is already in the pipeline on entry, so an empty
            // pipeline means its write is being presented this very cycle.
            if (r_valido == '0) begin
               w_estado_sig = FIN;
            end
         end
         FIN: begin
            w_terminado  = 1'b1;
            w_estado_sig = REPOSO;
         end
         default: begin
            w_estado_sig = REPOSO;
         end
      endcase
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_direccion     <= '0;
         r_restantes     <= '0;
         r_ultimo_buffer <= '0;
         r_buffer        <= '0;
         r_seleccion     <= '0;
         r_palabra       <= '0;
         r_valido        <= '0;
         r_dato          <= '0;
         r_escritura     <= 1'b0;
      end else begin
         r_valido    <= LATENCIA_MEM'({r_valido, w_lectura});
         r_escritura <= r_valido[LATENCIA_MEM-1];
         if (w_arranque) begin
            r_direccion     <= direccion_mem_inicio_imagen;
            r_restantes     <= cantidad_lecturas_mem;
            r_ultimo_buffer <= (cantidad_buffers_internos == '0) ? '0
                               : cantidad_buffers_internos - BITS_BUFFERS'(1);
            r_buffer        <= '0;
            r_seleccion     <= '0;
            r_palabra       <= '0;
         end else begin
            if (w_lectura) begin
               r_direccion <= r_direccion + BITS_DIRECCION_MEM'(1);
               r_restantes <= r_restantes - BITS_BUS_DATOS_INSTR'(1);
            end
            if (r_valido[LATENCIA_MEM-1]) begin
               r_dato      <= dato_mem;
               r_seleccion <= r_buffer;
               if (r_palabra == ULTIMA_PALABRA) begin
                  r_palabra <= '0;
                  r_buffer  <= (r_buffer == r_ultimo_buffer) ? '0 : r_buffer + BITS_BUFFERS'(1);
               end else begin
                  r_palabra <= r_palabra + BITS_PALABRAS'(1);
               end
            end
         end
      end
   end

   assign direccion_mem    = r_direccion;
   assign lectura_mem      = w_lectura;
   assign dato_buffer      = r_dato;
   assign escritura_buffer = r_escritura;
   assign seleccion_buffer = r_seleccion;
   assign ocupado          = w_ocupado;
   assign terminado        = w_terminado;

endmodule

// File: tb/tb_lector_memoria_ventana.sv
// Self-checking bench: a memory model answers reads, a scoreboard queue holds the
// expected word/select/cycle of each read and is compared against every buffer write.
module tb_lector_memoria_ventana;

   logic        clk = 1'b0;
   logic        reset;
   logic        inicio;
   logic [9:0]  direccion_mem_inicio_imagen;
   logic [23:0] cantidad_lecturas_mem;
   logic [2:0]  cantidad_buffers_internos;
   logic        buffer_listo;
   logic [31:0] dato_mem;
   logic [9:0]  direccion_mem;
   logic        lectura_mem;
   logic [31:0] dato_buffer;
   logic        escritura_buffer;
   logic [2:0]  seleccion_buffer;
   logic        ocupado;
   logic        terminado;

   lector_memoria_ventana dut (
      .clk                         (clk),
      .reset                       (reset),
      .inicio                      (inicio),
      .direccion_mem_inicio_imagen (direccion_mem_inicio_imagen),
      .cantidad_lecturas_mem       (cantidad_lecturas_mem),
      .cantidad_buffers_internos   (cantidad_buffers_internos),
      .buffer_listo                (buffer_listo),
      .dato_mem                    (dato_mem),
      .direccion_mem               (direccion_mem),
      .lectura_mem                 (lectura_mem),
      .dato_buffer                 (dato_buffer),
      .escritura_buffer            (escritura_buffer),
      .seleccion_buffer            (seleccion_buffer),
      .ocupado                     (ocupado),
      .terminado                   (terminado)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dato;
      logic [2:0]  sel;
      int          ciclo;
   } esperado_t;

   typedef struct {
      logic [9:0]  dir;
      int          n;
      logic [2:0]  nb;
      int          off_terminado;
      int          ciclos_ocupado;
      logic [2:0]  ultima_sel;
   } vector_t;

   esperado_t   cola[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic [9:0]  exp_dir;
   int          nbuf_ef;
   int          t0;
   int          n_reads, n_writes, n_term, n_ocup, n_gated, term_cyc, first_rd;
   logic [2:0]  last_sel;

   function automatic logic [31:0] mem_fn(input logic [9:0] a);
      return {6'h2A, a, 6'h15, ~a};
   endfunction

   task automatic check(input string nombre, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model with one cycle of latency; stale cycles return a poison word.
   always @(posedge clk) begin
      if (lectura_mem) dato_mem <= mem_fn(direccion_mem);
      else             dato_mem <= 32'hBAD0_BAD0;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (lectura_mem) begin
            esperado_t e;
            check("dir_lectura", direccion_mem, exp_dir);
            check("lectura_con_listo", buffer_listo, 1'b1);
            e.dato  = mem_fn(exp_dir);
            e.sel   = 3'((n_reads / 128) % nbuf_ef);
            e.ciclo = cyc;
            cola.push_back(e);
            if (n_reads == 0) first_rd = cyc;
            exp_dir = exp_dir + 10'd1;
            n_reads++;
         end
         if (escritura_buffer) begin
            if (!buffer_listo) n_gated++;
            if (cola.size() == 0) begin
               check("escritura_sin_lectura", 1'b1, 1'b0);
            end else begin
               esperado_t e;
               e = cola.pop_front();
               check("dato_buffer", dato_buffer, e.dato);
               check("seleccion_buffer", seleccion_buffer, e.sel);
               check("latencia_escritura", cyc - e.ciclo, 2);
            end
            last_sel = seleccion_buffer;
            n_writes++;
         end
         if (terminado) begin
            n_term++;
            term_cyc = cyc;
         end
         if (ocupado) n_ocup++;
      end
   end

   task automatic limpiar_stats();
      n_reads = 0; n_writes = 0; n_term = 0; n_ocup = 0; n_gated = 0;
      term_cyc = -1; first_rd = -1; last_sel = 3'd0;
      cola.delete();
   endtask

   // Drives a one-cycle start, then scrambles the configuration inputs to prove they were latched.
   task automatic arrancar(input logic [9:0] dir, input int n, input logic [2:0] nb);
      @(negedge clk);
      limpiar_stats();
      direccion_mem_inicio_imagen = dir;
      cantidad_lecturas_mem       = 24'(n);
      cantidad_buffers_internos   = nb;
      inicio  = 1'b1;
      exp_dir = dir;
      nbuf_ef = (nb == 3'd0) ? 1 : int'(nb);
      t0      = cyc + 1;
      mon_en  = 1'b1;
      @(negedge clk);
      inicio = 1'b0;
      direccion_mem_inicio_imagen = 10'h3C3;
      cantidad_lecturas_mem       = 24'd7;
      cantidad_buffers_internos   = 3'd5;
   endtask

   task automatic esperar_fin(input int limite);
      int k;
      k = 0;
      while (n_term == 0 && k < limite) begin
         @(negedge clk);
         k++;
      end
      check("fin_a_tiempo", (n_term > 0), 1'b1);
      repeat (4) @(negedge clk);
      check("ocupado_tras_fin", ocupado, 1'b0);
   endtask

   vector_t tabla[7];

   initial begin
      tabla[0] = '{dir: 10'h010, n: 4,   nb: 3'd2, off_terminado: 6,   ciclos_ocupado: 7,   ultima_sel: 3'd0};
      tabla[1] = '{dir: 10'h3FE, n: 4,   nb: 3'd1, off_terminado: 6,   ciclos_ocupado: 7,   ultima_sel: 3'd0};
      tabla[2] = '{dir: 10'h100, n: 300, nb: 3'd2, off_terminado: 302, ciclos_ocupado: 303, ultima_sel: 3'd0};
      tabla[3] = '{dir: 10'h055, n: 1,   nb: 3'd0, off_terminado: 3,   ciclos_ocupado: 4,   ultima_sel: 3'd0};
      tabla[4] = '{dir: 10'h200, n: 0,   nb: 3'd3, off_terminado: 0,   ciclos_ocupado: 1,   ultima_sel: 3'd0};
      tabla[5] = '{dir: 10'h300, n: 300, nb: 3'd3, off_terminado: 302, ciclos_ocupado: 303, ultima_sel: 3'd2};
      tabla[6] = '{dir: 10'h3F0, n: 130, nb: 3'd4, off_terminado: 132, ciclos_ocupado: 133, ultima_sel: 3'd1};

      reset = 1'b0;
      inicio = 1'b0;
      buffer_listo = 1'b1;
      direccion_mem_inicio_imagen = '0;
      cantidad_lecturas_mem = '0;
      cantidad_buffers_internos = '0;
      limpiar_stats();
      repeat (3) @(negedge clk);
      check("rst_direccion", direccion_mem, 0);
      check("rst_lectura", lectura_mem, 0);
      check("rst_dato", dato_buffer, 0);
      check("rst_escritura", escritura_buffer, 0);
      check("rst_seleccion", seleccion_buffer, 0);
      check("rst_ocupado", ocupado, 0);
      check("rst_terminado", terminado, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         arrancar(tabla[i].dir, tabla[i].n, tabla[i].nb);
         esperar_fin(tabla[i].n + 50);
         check("lecturas", n_reads, tabla[i].n);
         check("escrituras", n_writes, tabla[i].n);
         check("terminado_unico", n_term, 1);
         check("ciclo_terminado", term_cyc - t0, tabla[i].off_terminado);
         check("ciclos_ocupado", n_ocup, tabla[i].ciclos_ocupado);
         check("ultima_sel", last_sel, tabla[i].ultima_sel);
         check("cola_vacia", cola.size(), 0);
         if (tabla[i].n > 0) check("primera_lectura", first_rd - t0, 0);
      end

      // buffer_listo low for three cycles after the 2nd read; an inicio pulse mid-read is ignored.
      arrancar(10'h020, 5, 3'd1);
      @(posedge clk);
      @(posedge clk); #1;
      buffer_listo = 1'b0;
      inicio = 1'b1;
      cantidad_lecturas_mem = 24'd1;
      @(posedge clk); #1;
      inicio = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      buffer_listo = 1'b1;
      esperar_fin(60);
      check("gap_lecturas", n_reads, 5);
      check("gap_escrituras", n_writes, 5);
      check("gap_escrituras_sin_listo", n_gated, 2);
      check("gap_ciclo_terminado", term_cyc - t0, 10);
      check("gap_terminado_unico", n_term, 1);

      // Count 0, with a second inicio arriving while ocupado is high.
      arrancar(10'h111, 0, 3'd2);
      inicio = 1'b1;
      cantidad_lecturas_mem = 24'd3;
      @(negedge clk);
      inicio = 1'b0;
      repeat (6) @(negedge clk);
      check("cero_terminado_unico", n_term, 1);
      check("cero_ciclo_terminado", term_cyc - t0, 0);
      check("cero_lecturas", n_reads, 0);
      check("cero_escrituras", n_writes, 0);
      check("cero_ocupado", n_ocup, 1);

      // Reset asserted mid-read after 3 of 8 reads.
      arrancar(10'h080, 8, 3'd1);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      check("reset_medio_lecturas_previas", n_reads, 3);
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check("reset_medio_direccion", direccion_mem, 0);
      check("reset_medio_lectura", lectura_mem, 0);
      check("reset_medio_dato", dato_buffer, 0);
      check("reset_medio_escritura", escritura_buffer, 0);
      check("reset_medio_seleccion", seleccion_buffer, 0);
      check("reset_medio_ocupado", ocupado, 0);
      check("reset_medio_terminado", terminado, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      limpiar_stats();
      mon_en = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_lecturas", n_reads, 0);
      check("post_reset_escrituras", n_writes, 0);
      check("post_reset_ocupado", n_ocup, 0);
      check("post_reset_terminado", n_term, 0);
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lector_memoria_ventana.md
Name: lector_memoria_ventana

Overview:
- Read sequencer directly downstream of the window configuration register block.
- Consumes the image start address, read count and internal-buffer count latched there, and issues sequential reads to the image memory.
- Streams returned words into the configurable line buffer, rotating across the selected internal buffers.
- Sits between the configuration registers, the memory port and the configurable buffer.

Parameters:
BITS_BUS_DATOS_INSTR, 24, width of the read-count input and the internal remaining-reads counter
BITS_DIRECCION_MEM, 10, memory address width
BITS_BUFFERS, 3, width of the internal-buffer count and of the buffer select
BITS_DATOS_MEM, 32, memory data word width
LATENCIA_MEM, 1, fixed memory read latency in cycles (≥1)
PALABRAS_POR_BUFFER, 128, words written to one internal buffer before rotating to the next
BITS_PALABRAS, 7, width of the per-buffer word counter (log2 PALABRAS_POR_BUFFER)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
inicio  input  1  single-cycle start pulse
direccion_mem_inicio_imagen  input  BITS_DIRECCION_MEM  first address to read
cantidad_lecturas_mem  input  BITS_BUS_DATOS_INSTR  number of memory reads to issue
cantidad_buffers_internos  input  BITS_BUFFERS  number of internal buffers to rotate through
buffer_listo  input  1  downstream can accept new reads; read issue is gated by it
dato_mem  input  BITS_DATOS_MEM  memory read data, valid LATENCIA_MEM cycles after lectura_mem
direccion_mem  output  BITS_DIRECCION_MEM  memory read address
lectura_mem  output  1  memory read strobe
dato_buffer  output  BITS_DATOS_MEM  word to the line buffer
escritura_buffer  output  1  write strobe to the line buffer
seleccion_buffer  output  BITS_BUFFERS  internal buffer targeted by the current write
ocupado  output  1  sequence in progress
terminado  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state REPOSO.
  - All outputs 0.
  - All counters and the read-valid pipeline cleared.
  - Reset mid-sequence aborts it; no further reads or writes are issued.
- FSM states: REPOSO, LEYENDO, DRENANDO, FIN.
- REPOSO, on inicio=1 sampled at edge T:
  - Latch the three configuration inputs.
  - Latched buffer count of 0 is treated as 1.
  - Go to LEYENDO, or to FIN if the count is 0.
  - Later changes on the configuration inputs have no effect until the next start.
- inicio is ignored in every state except REPOSO.
- LEYENDO:
  - Each cycle with buffer_listo=1: lectura_mem=1, direccion_mem=current address.
  - The address then increments, wrapping modulo 2^BITS_DIRECCION_MEM.
  - The remaining-reads counter decrements.
  - buffer_listo=0 forces lectura_mem=0; address and counter hold.
  - On issuing the last read, go to DRENANDO.
- Read-valid pipeline: LATENCIA_MEM-stage shift of lectura_mem.
  - At its tail, dato_mem is registered into dato_buffer with escritura_buffer=1.
  - Each write therefore appears exactly LATENCIA_MEM+1 cycles after its lectura_mem.
  - In-flight words are always delivered regardless of buffer_listo; the buffer must absorb up to LATENCIA_MEM+1 words after deasserting it.
- Buffer rotation:
  - The word counter counts writes 0..PALABRAS_POR_BUFFER-1.
  - seleccion_buffer starts at 0 and accompanies each write.
  - After the PALABRAS_POR_BUFFER-th write to a buffer, seleccion_buffer increments, wrapping to 0 after latched count-1.
  - Word counter and select are reset to 0 at every start.
- DRENANDO: stay until the pipeline is empty and the final write has been output, then go to FIN.
- FIN: terminado=1 for exactly one cycle, then REPOSO.
  - terminado occurs in the cycle after the final escritura_buffer.
  - For a count of 0, terminado occurs at T+1.
- ocupado is 1 from cycle T+1 through the terminado cycle inclusive, else 0.
- Outputs when idle: lectura_mem=0, escritura_buffer=0; direccion_mem and dato_buffer hold their last value.

Test Plan:
- Reset, then start=0x010, count=4, buffers=2, buffer_listo=1, LATENCIA_MEM=1 -> reads at 0x010..0x013 in cycles T+1..T+4; writes T+3..T+6 with seleccion_buffer=0; terminado at T+7; ocupado high T+1..T+7.
- count=300, buffers=2, PALABRAS_POR_BUFFER=128 -> writes 0–127 sel=0, 128–255 sel=1, 256–299 sel=0; exactly 300 writes, terminado once.
- start=0x3FE, count=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- buffer_listo low for 3 cycles after the 2nd read, count=5 -> no lectura_mem while low; 5 reads total with contiguous addresses; the in-flight word is still written; data order preserved.
- count=0 -> no reads or writes; terminado at T+1; second inicio while ocupado=1 -> ignored, no extra terminado.
- reset asserted mid-LEYENDO after 3 of 8 reads -> all outputs 0 immediately; after release, no activity until a new inicio.
